shift_register_ctl: RTL and testbench
=====================================

# shift_register_ctl

- Parametrised universal register: parallel load, clear, hold, and multi-bit shift/rotate sequenced one bit position per clock.
- Status outputs: busy, done and carry.
- Replaces fixed-width load/hold registers wherever the datapath needs shifting, rotation or serial fill.
- Sits between control logic, which issues commands, and the datapath, which consumes data_out.

## Interface
- WIDTH, 8, register width in bits (≥2).
- AW, $clog2(WIDTH)+1, width of the amount field; max shift = 2^AW−1.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; accepted only when busy=0.
- op  in  3  command code:
  - 000 nop
  - 001 load
  - 010 logical shift left
  - 011 logical shift right
  - 100 arithmetic shift right
  - 101 rotate left
  - 110 rotate right
  - 111 clear
- amount  in  AW  number of bit positions; used by ops 010–110 only.
- data_in  in  WIDTH  load value.
- ser_in  in  1  fill bit for logical shifts (ops 010/011).
- data_out  out  WIDTH  register contents.
- busy  out  1  high while a multi-step shift is in progress.
- done  out  1  one-cycle pulse on command completion.
- carry_out  out  1  last bit shifted or rotated out.

## Operation
- States: IDLE, SHIFT. Step counter is AW bits.
- IDLE with start=1, at the next edge:
  - nop: no register change; done pulses.
  - load: data_out ← data_in; done pulses; carry_out unchanged.
  - clear: data_out ← 0 and carry_out ← 0; done pulses.
  - shift/rotate, amount=0: no change; done pulses; carry_out unchanged.
  - shift/rotate, amount=1: one step performed; done pulses; stay IDLE.
  - shift/rotate, amount≥2: one step performed; counter ← amount−1; go to SHIFT; busy=1.
- SHIFT: one step per edge, counter decrements.
  - On the edge where counter goes 1→0: final step, go to IDLE, busy←0, done←1.
- Step definitions (carry_out ← bit leaving the register):
  - shl: {d[W−2:0], ser_in}, carry=d[W−1].
  - shr: {ser_in, d[W−1:1]}, carry=d[0].
  - sar: {d[W−1], d[W−1:1]}, carry=d[0].
  - rol: {d[W−2:0], d[W−1]}, carry=d[W−1].
  - ror: {d[0], d[W−1:1]}, carry=d[0].
- op and amount are latched at accept; later changes do not affect the running command.
- ser_in is sampled live on every step edge.
- amount ≥ WIDTH is legal and not clamped:
  - logical shifts fill the register entirely with ser_in;
  - rotates wrap modulo WIDTH;
  - sar saturates to all sign bits.
- start while busy=1 is ignored: no queuing, no error flag.

## Timing
- Reset (RST=0, asynchronous): data_out=0, busy=0, done=0, carry_out=0, state IDLE, counter=0.
- Reset mid-SHIFT aborts the command immediately; no done pulse.
- Latency:
  - load/clear/nop: 1 edge; done high in the following cycle.
  - shift of n≥1: n edges; done high in the cycle after the n-th edge.
- busy rises after the accept edge (n≥2) and falls on the final-step edge.
- busy and done are never high together.
- done is high for exactly one cycle per accepted command.
- Back-to-back: start asserted during the done cycle is accepted at the next edge, with no idle gap.
- data_out changes only on step, load or clear edges; it holds otherwise.

## Test plan
- Reset: drive RST=0 asynchronously mid-cycle -> all outputs 0 immediately; after release with start=0, data_out stays 0x00.
- Load: WIDTH=8, start, op=001, data_in=0xA5 -> data_out=0xA5 after 1 edge; done one cycle; busy never high; carry unchanged.
- Rotate: load 0x81, then rol, amount=3 -> busy high 2 cycles, data_out steps 0x03, 0x06, 0x0C, carry_out=0, done once.
- Arithmetic shift: load 0x90, sar, amount=2 -> 0xC8 then 0xE4, carry_out=0.
  - Then ror, amount=9 -> 0x72, carry_out=0.
- Fill past width: clear, shl, amount=10, ser_in=1 -> 0xFF after 10 edges, carry_out=1.
  - start with op=001 during busy -> ignored, data_out unaffected.
- Abort and re-issue: reset asserted on the 2nd step of a shr, amount=5 -> outputs 0, no done.
  - After release, load 0x3C -> 0x3C, done pulses normally.

Source files
------------

// File: rtl/shift_register_ctl.sv
`default_nettype none
// ============================================================================
// shift_register_ctl : universal register with load, clear, hold and
//                      multi-step shift/rotate sequenced one bit per clock.
// Revision: 1.0
// ============================================================================
module shift_register_ctl #(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    amount,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ser_in,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             carry_out
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_SHL   = 3'b010;
   localparam logic [2:0] OP_SHR   = 3'b011;
   localparam logic [2:0] OP_SAR   = 3'b100;
   localparam logic [2:0] OP_ROL   = 3'b101;
   localparam logic [2:0] OP_ROR   = 3'b110;
   localparam logic [2:0] OP_CLEAR = 3'b111;

   localparam logic [AW-1:0] CNT_ZERO = '0;
   localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    cnt_q,   cnt_d;
   logic [2:0]       op_q,    op_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             carry_q, carry_d;
   logic             done_q,  done_d;

   logic [2:0]       step_op;
   logic [WIDTH-1:0] step_data;
   logic             step_carry;

   // A running command uses its latched opcode; a fresh command uses the live one.
   always_comb begin
      step_op = (state_q == ST_SHIFT) ? op_q : op;
   end

   always_comb begin
      step_data  = data_q;
      step_carry = carry_q;
      case (step_op)
         OP_SHL: begin
            step_data  = {data_q[WIDTH-2:0], ser_in};
            step_carry = data_q[WIDTH-1];
         end
         OP_SHR: begin
            step_data  = {ser_in, data_q[WIDTH-1:1]};
            step_carry = data_q[0];
         end
         OP_SAR: begin
            step_data  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            step_carry = data_q[0];
         end
         OP_ROL: begin
            step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            step_carry = data_q[WIDTH-1];
         end
         OP_ROR: begin
            step_data  = {data_q[0], data_q[WIDTH-1:1]};
            step_carry = data_q[0];
         end
         default: begin
            step_data  = data_q;
            step_carry = carry_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      data_d  = data_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  OP_NOP: begin
                     done_d = 1'b1;
                  end
                  OP_LOAD: begin
                     data_d = data_in;
                     done_d = 1'b1;
                  end
                  OP_CLEAR: begin
                     data_d  = '0;
                     carry_d = 1'b0;
                     done_d  = 1'b1;
                  end
                  default: begin
                     if (amount == CNT_ZERO) begin
                        done_d = 1'b1;
                     end else begin
                        data_d  = step_data;
                        carry_d = step_carry;
                        if (amount == CNT_ONE) begin
                           done_d = 1'b1;
                        end else begin
                           cnt_d   = amount - CNT_ONE;
                           op_d    = op;
                           state_d = ST_SHIFT;
                        end
                     end
                  end
               endcase
            end
         end
         default: begin
            data_d  = step_data;
            carry_d = step_carry;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         data_q  <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign data_out  = data_q;
   assign carry_out = carry_q;
   assign done      = done_q;
   assign busy      = (state_q == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_shift_register_ctl.sv
`default_nettype none
// ============================================================================
// tb_shift_register_ctl : self-checking bench with directed scenarios and a
//                         randomized run against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_shift_register_ctl;

   localparam int W  = 8;
   localparam int AW = $clog2(W) + 1;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] amount;
   logic [W-1:0]  data_in;
   logic          ser_in;
   logic [W-1:0]  data_out;
   logic          busy;
   logic          done;
   logic          carry_out;

   int checks;
   int errors;

   logic [W-1:0] m_data;
   logic         m_carry;

   shift_register_ctl #(.WIDTH(W), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .amount    (amount),
      .data_in   (data_in),
      .ser_in    (ser_in),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Whole-command result computed from the operation's meaning, not step by step.
   task automatic model_cmd(input logic [2:0] o, input int n, input logic [W-1:0] d, input logic s);
      logic [15:0] m;
      logic [W-1:0] fill;
      int k;
      m    = {8'h00, m_data};
      fill = s ? 8'hFF : 8'h00;
      case (o)
         3'b001: m_data = d;
         3'b111: begin m_data = '0; m_carry = 1'b0; end
         3'b000: ;
         default: if (n > 0) begin
            case (o)
               3'b010: begin
                  if (n >= W) begin
                     m_carry = (n == W) ? m[0] : s;
                     m_data  = fill;
                  end else begin
                     m_carry = m[W-n];
                     m_data  = 8'((m << n) | (s ? ((16'd1 << n) - 16'd1) : 16'd0));
                  end
               end
               3'b011: begin
                  if (n >= W) begin
                     m_carry = (n == W) ? m[W-1] : s;
                     m_data  = fill;
                  end else begin
                     m_carry = m[n-1];
                     m_data  = 8'((m >> n) | (s ? (16'hFF << (W-n)) : 16'd0));
                  end
               end
               3'b100: begin
                  m_carry = (n >= W) ? m[W-1] : m[n-1];
                  m_data  = (n >= W) ? {W{m[W-1]}} : 8'($signed(m_data) >>> n);
               end
               3'b101: begin
                  k       = n % W;
                  m_data  = 8'((m << k) | (m >> (W-k)));
                  m_carry = m_data[0];
               end
               default: begin
                  k       = n % W;
                  m_data  = 8'((m >> k) | (m << (W-k)));
                  m_carry = m_data[W-1];
               end
            endcase
         end
      endcase
   endtask

   // Issues one command from a negedge and returns at the negedge where done is seen.
   task automatic run_cmd(input logic [2:0] o, input int a, input logic [W-1:0] d, input logic s,
                          output int lat, output int busy_cnt, output bit overlap);
      start   = 1'b1;
      op      = o;
      amount  = AW'(a);
      data_in = d;
      ser_in  = s;
      lat = 0; busy_cnt = 0; overlap = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start   = 1'b0;
            op      = 3'($urandom);
            amount  = AW'($urandom);
            data_in = W'($urandom);
         end
         lat++;
         if (busy) busy_cnt++;
         if (busy && done) overlap = 1;
         if (done) break;
      end
      if (!done) lat = -1;
      model_cmd(o, a, d, s);
   endtask

   function automatic int exp_lat(input logic [2:0] o, input int a);
      if (o == 3'b000 || o == 3'b001 || o == 3'b111 || a == 0) return 1;
      return a;
   endfunction

   task automatic test_reset();
      int lat, bc; bit ov;
      run_cmd(3'b001, 0, 8'hA5, 1'b0, lat, bc, ov);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: data=%h busy=%b done=%b carry=%b required 00/0/0/0",
                  data_out, busy, done, carry_out);
      end
      @(negedge clk); rst_n = 1'b1;
      m_data = '0; m_carry = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (data_out !== 8'h00 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_hold: data=%h done=%b required 00/0", data_out, done);
      end
   endtask

   task automatic test_load();
      int lat, bc; bit ov;
      logic c0;
      c0 = carry_out;
      run_cmd(3'b001, 0, 8'hA5, 1'b0, lat, bc, ov);
      checks++;
      if (data_out !== 8'hA5 || lat != 1 || bc != 0 || carry_out !== c0) begin
         errors++;
         $display("FAIL load: data=%h lat=%0d busy_cycles=%0d carry=%b required a5/1/0/%b",
                  data_out, lat, bc, carry_out, c0);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || data_out !== 8'hA5) begin
         errors++;
         $display("FAIL load_done_width: done=%b data=%h required 0/a5", done, data_out);
      end
   endtask

   task automatic test_rotate();
      int lat, bc; bit ov;
      logic [W-1:0] seen [3];
      run_cmd(3'b001, 0, 8'h81, 1'b0, lat, bc, ov);
      start = 1'b1; op = 3'b101; amount = AW'(3);
      @(posedge clk); #1 seen[0] = data_out; start = 1'b0;
      @(posedge clk); #1 seen[1] = data_out;
      @(posedge clk); #1 seen[2] = data_out;
      checks++;
      if (seen[0] !== 8'h03 || seen[1] !== 8'h06 || seen[2] !== 8'h0C) begin
         errors++;
         $display("FAIL rol_steps: got %h %h %h required 03 06 0c", seen[0], seen[1], seen[2]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL rol_done: done=%b busy=%b carry=%b required 1/0/0", done, busy, carry_out);
      end
      run_cmd(3'b000, 0, 8'h00, 1'b0, lat, bc, ov);
      m_data = 8'h0C; m_carry = 1'b0;
   endtask

   task automatic test_sar_ror();
      int lat, bc; bit ov;
      run_cmd(3'b001, 0, 8'h90, 1'b0, lat, bc, ov);
      run_cmd(3'b100, 2, 8'h00, 1'b1, lat, bc, ov);
      checks++;
      if (data_out !== 8'hE4 || carry_out !== 1'b0 || lat != 2 || bc != 1) begin
         errors++;
         $display("FAIL sar2: data=%h carry=%b lat=%0d busy=%0d required e4/0/2/1",
                  data_out, carry_out, lat, bc);
      end
      run_cmd(3'b110, 9, 8'h00, 1'b1, lat, bc, ov);
      checks++;
      if (data_out !== 8'h72 || carry_out !== 1'b0 || lat != 9 || ov) begin
         errors++;
         $display("FAIL ror9: data=%h carry=%b lat=%0d overlap=%b required 72/0/9/0",
                  data_out, carry_out, lat, ov);
      end
   endtask

   task automatic test_fill_and_ignore();
      int lat, bc; bit ov;
      int edges;
      run_cmd(3'b111, 0, 8'h00, 1'b0, lat, bc, ov);
      start = 1'b1; op = 3'b010; amount = AW'(10); ser_in = 1'b1;
      @(negedge clk); start = 1'b0; edges = 1;
      start = 1'b1; op = 3'b001; data_in = 8'h55;
      @(negedge clk); start = 1'b0; edges++;
      while (!done && edges < 50) begin
         @(negedge clk); edges++;
      end
      checks++;
      if (data_out !== 8'hFF || carry_out !== 1'b1 || edges != 10) begin
         errors++;
         $display("FAIL shl10_fill: data=%h carry=%b edges=%0d required ff/1/10",
                  data_out, carry_out, edges);
      end
      @(negedge clk);
      checks++;
      if (data_out !== 8'hFF || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_during_busy: data=%h done=%b busy=%b required ff/0/0",
                  data_out, done, busy);
      end
      m_data = 8'hFF; m_carry = 1'b1;
   endtask

   task automatic test_abort();
      int lat, bc; bit ov;
      bit saw_done;
      run_cmd(3'b001, 0, 8'hF0, 1'b0, lat, bc, ov);
      start = 1'b1; op = 3'b011; amount = AW'(5); ser_in = 1'b1;
      @(negedge clk); start = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      checks++;
      if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: data=%h busy=%b done=%b carry=%b required 00/0/0/0",
                  data_out, busy, done, carry_out);
      end
      @(negedge clk); rst_n = 1'b1;
      saw_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      checks++;
      if (saw_done || data_out !== 8'h00) begin
         errors++;
         $display("FAIL abort_no_done: done_seen=%b data=%h required 0/00", saw_done, data_out);
      end
      m_data = '0; m_carry = 1'b0;
      run_cmd(3'b001, 0, 8'h3C, 1'b0, lat, bc, ov);
      checks++;
      if (data_out !== 8'h3C || lat != 1) begin
         errors++;
         $display("FAIL reload_after_abort: data=%h lat=%0d required 3c/1", data_out, lat);
      end
   endtask

   task automatic test_random();
      int lat, bc; bit ov;
      logic [2:0] o; int a; logic [W-1:0] d; logic s;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom);
         if (o == 3'b111 && ($urandom % 3 != 0)) o = 3'b101;
         a = int'($urandom_range(0, (1 << AW) - 1));
         d = W'($urandom);
         s = 1'($urandom);
         run_cmd(o, a, d, s, lat, bc, ov);
         checks++;
         if (data_out !== m_data || carry_out !== m_carry) begin
            errors++;
            $display("FAIL rand_result[%0d] op=%0d amt=%0d: data=%h carry=%b required %h/%b",
                     i, o, a, data_out, carry_out, m_data, m_carry);
         end
         checks++;
         if (lat != exp_lat(o, a) || bc != ((exp_lat(o, a) >= 2) ? exp_lat(o, a) - 1 : 0) || ov) begin
            errors++;
            $display("FAIL rand_timing[%0d] op=%0d amt=%0d: lat=%0d busy=%0d overlap=%b required %0d/%0d/0",
                     i, o, a, lat, bc, ov, exp_lat(o, a),
                     (exp_lat(o, a) >= 2) ? exp_lat(o, a) - 1 : 0);
         end
         if (i % 5 == 0) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || data_out !== m_data) begin
               errors++;
               $display("FAIL rand_idle[%0d]: done=%b data=%h required 0/%h", i, done, data_out, m_data);
            end
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; start = 1'b0; op = 3'b000; amount = '0; data_in = '0; ser_in = 1'b0;
      m_data = '0; m_carry = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_load();
      test_rotate();
      test_sar_ror();
      test_fill_and_ignore();
      test_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
